// File: rtl/deinterleaver_if.sv
// +-----------------------------------------------------------------------------+
// | deinterleaver_if: sample stream in, deinterleaved burst and drop flag out.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface deinterleaver_if #(
  parameter int WIDTH = 16
);
  logic             din_valid;
  logic             din_sof;
  logic [WIDTH-1:0] din;
  logic             dout_valid;
  logic             dout_sof;
  logic [WIDTH-1:0] dout;
  logic             blk_drop;

  modport master (
    output din_valid, din_sof, din,
    input  dout_valid, dout_sof, dout, blk_drop
  );

  modport slave (
    input  din_valid, din_sof, din,
    output dout_valid, dout_sof, dout, blk_drop
  );
endinterface

`default_nettype wire

// File: rtl/deinterleaver.sv
// +-----------------------------------------------------------------------------+
// | deinterleaver: ping-pong RAM block deinterleaver (ROWS x COLS matrix).      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module deinterleaver #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 12,
  parameter int COLS  = 16
) (
  input  wire logic          clk,
  input  wire logic          reset,
  deinterleaver_if.slave     bus
);

  localparam int c_N   = ROWS * COLS;
  localparam int c_AW  = $clog2(2 * c_N);
  localparam int c_RAW = $clog2(c_N);
  localparam int c_RW  = $clog2(ROWS);
  localparam int c_CW  = $clog2(COLS);

  typedef enum logic [0:0] {S_IDLE, S_READ} state_t;

  logic [WIDTH-1:0] r_mem [0:2*c_N-1];

  logic [c_RW-1:0]  r_wr_row;
  logic [c_CW-1:0]  r_wr_col;
  logic             r_wr_bank;
  logic [1:0]       r_full;
  logic             r_blk_drop;

  state_t           r_state, w_state_nxt;
  logic [c_RAW-1:0] r_rd_addr, w_rd_addr_nxt;
  logic             r_rd_bank, w_rd_bank_nxt;
  logic             w_issue;
  logic [c_RAW-1:0] w_issue_idx;
  logic [c_AW-1:0]  w_rd_ram_addr;

  logic             r_dout_valid;
  logic             r_dout_sof;
  logic [WIDTH-1:0] r_dout;

  logic             w_wr_at_zero;
  logic             w_wr_last;
  logic [c_AW-1:0]  w_wr_base;
  logic [c_AW-1:0]  w_wr_addr;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;

  // Write side: column-ordered input lands row-major in the current bank
  assign w_wr_at_zero = (r_wr_row == '0) && (r_wr_col == '0);
  assign w_wr_last    = (r_wr_row == c_RW'(ROWS - 1)) && (r_wr_col == c_CW'(COLS - 1));
  assign w_wr_base    = r_wr_bank ? c_AW'(c_N) : c_AW'(0);
  assign w_wr_addr    = bus.din_sof ? w_wr_base
                      : w_wr_base + c_AW'(r_wr_row) * c_AW'(COLS) + c_AW'(r_wr_col);
  assign w_full_set   = (bus.din_valid && !bus.din_sof && w_wr_last)
                      ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (!reset && bus.din_valid) begin
      r_mem[w_wr_addr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_bank  <= 1'b0;
      r_blk_drop <= 1'b0;
    end else begin
      r_blk_drop <= bus.din_valid && bus.din_sof && !w_wr_at_zero;
      if (bus.din_valid) begin
        if (bus.din_sof) begin
          // A sof sample always becomes index 0, so the next one is row 1
          r_wr_row <= c_RW'(1);
          r_wr_col <= '0;
        end else if (w_wr_last) begin
          r_wr_row  <= '0;
          r_wr_col  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else if (r_wr_row == c_RW'(ROWS - 1)) begin
          r_wr_row <= '0;
          r_wr_col <= r_wr_col + c_CW'(1);
        end else begin
          r_wr_row <= r_wr_row + c_RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Idle issues address 0 itself, so a waiting second block follows with no gap
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_rd_bank_nxt = r_rd_bank;
    w_issue       = 1'b0;
    w_issue_idx   = '0;
    w_full_clr    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_issue       = 1'b1;
          w_rd_addr_nxt = c_RAW'(1);
          w_state_nxt   = S_READ;
        end
      end
      S_READ: begin
        w_issue     = 1'b1;
        w_issue_idx = r_rd_addr;
        if (r_rd_addr == c_RAW'(c_N - 1)) begin
          w_full_clr    = r_rd_bank ? 2'b10 : 2'b01;
          w_rd_bank_nxt = ~r_rd_bank;
          w_rd_addr_nxt = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_rd_addr_nxt = r_rd_addr + c_RAW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_ram_addr = (r_rd_bank ? c_AW'(c_N) : c_AW'(0)) + c_AW'(w_issue_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_valid <= 1'b0;
      r_dout_sof   <= 1'b0;
      r_dout       <= '0;
    end else begin
      r_dout_valid <= w_issue;
      r_dout_sof   <= w_issue && (w_issue_idx == '0);
      if (w_issue) begin
        r_dout <= r_mem[w_rd_ram_addr];
      end
    end
  end

  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_sof   = r_dout_sof;
  assign bus.dout       = r_dout;
  assign bus.blk_drop   = r_blk_drop;

endmodule

`default_nettype wire
